// File: rtl/decoder_pkg.sv
// decoder_pkg: shared FSM states, legal select-width range and a one-hot helper for the sequential decoder.
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 6;
  function automatic logic [63:0] onehot(input int unsigned idx, input int unsigned width);
    return (idx < width) ? (64'd1 << idx) : 64'd0;
  endfunction
endpackage

// File: rtl/decoder_seq_nx2n_if.sv
// decoder_seq_nx2n_if: decode/sweep bus (enable, IN, sweep_req, sweep_abort in; OUT, valid, busy, done out).
interface decoder_seq_nx2n_if #(parameter int N_IN = 3);
  localparam int OUT_W = 2 ** N_IN;
  logic enable;
  logic [N_IN-1:0] IN;
  logic sweep_req;
  logic sweep_abort;
  logic [OUT_W-1:0] OUT;
  logic valid;
  logic busy;
  logic done;
  modport master(output enable, IN, sweep_req, sweep_abort, input OUT, valid, busy, done);
  modport slave(input enable, IN, sweep_req, sweep_abort, output OUT, valid, busy, done);
endinterface

// File: rtl/decoder_nx2n.sv
// decoder_nx2n: combinational enable-gated N-to-2^N one-hot decoder (en, sel in; y out), split recursively on the MSB.
module decoder_nx2n #(parameter int N_IN = 3) (
  input  logic              en,
  input  logic [N_IN-1:0]   sel,
  output logic [2**N_IN-1:0] y
);
  if (N_IN == 1) begin : g_leaf
    assign y = {en & sel[0], en & ~sel[0]};
  end else begin : g_split
    localparam int H = 2 ** (N_IN - 1);
    decoder_nx2n #(.N_IN(N_IN - 1)) u_hi (.en(en & sel[N_IN-1]), .sel(sel[N_IN-2:0]), .y(y[2*H-1:H]));
    decoder_nx2n #(.N_IN(N_IN - 1)) u_lo (.en(en & ~sel[N_IN-1]), .sel(sel[N_IN-2:0]), .y(y[H-1:0]));
  end
endmodule

// File: rtl/decoder_seq_nx2n.sv
// decoder_seq_nx2n: registered one-hot decoder with sweep mode (clk, reset, bus: decode/sweep handshake slave).
module decoder_seq_nx2n
  import decoder_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter bit ACTIVE_LOW = 0
) (
  input logic clk,
  input logic reset,
  decoder_seq_nx2n_if.slave bus
);
  localparam int OUT_W = 2 ** N_IN;
  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("decoder_seq_nx2n: N_IN out of range");
  end
  state_t state_q, state_d;
  logic [N_IN-1:0] cnt_q, cnt_d, sel;
  logic [OUT_W-1:0] dec, out_q;
  logic dec_en, valid_d, valid_q, done_d, done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = bus.IN;
    dec_en  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = bus.sweep_req ? SWEEP : IDLE;
        cnt_d   = bus.sweep_req ? '0 : cnt_q;
        dec_en  = bus.enable & ~bus.sweep_req;
        valid_d = dec_en;
      end
      SWEEP: begin
        sel     = cnt_q;
        dec_en  = ~bus.sweep_abort;
        cnt_d   = bus.sweep_abort ? cnt_q : cnt_q + 1'b1;
        state_d = bus.sweep_abort ? IDLE : (&cnt_q ? DONE : SWEEP);
      end
      DONE: begin
        // First DONE cycle emits the done pulse; the second returns to IDLE.
        done_d  = ~done_q;
        state_d = done_q ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  decoder_nx2n #(.N_IN(N_IN)) u_dec (.en(dec_en), .sel(sel), .y(dec));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= {OUT_W{ACTIVE_LOW}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= ACTIVE_LOW ? ~dec : dec;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  assign bus.OUT   = out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// tb_decoder_seq_nx2n: scoreboard bench for two decoder configurations (3-bit active-high, 5-bit active-low).
module tb_decoder_seq_nx2n;
  typedef struct {
    logic [63:0] out;
    logic valid;
    logic busy;
    logic done;
  } exp_t;
  logic clk = 0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int plan0[$];
  int plan1[$];
  decoder_seq_nx2n_if #(.N_IN(3)) b0 ();
  decoder_seq_nx2n_if #(.N_IN(5)) b1 ();
  decoder_seq_nx2n #(.N_IN(3), .ACTIVE_LOW(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  decoder_seq_nx2n #(.N_IN(5), .ACTIVE_LOW(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  // Reference model: a sweep is a pre-planned list of frames (lines 0..W-1, then
  // a done frame (-1), then a closing idle frame (-2)); inputs other than reset are
  // ignored while frames remain, and abort cancels only while a line frame is next.
  task automatic model(input int d, input int w, input bit al, input bit r, input bit en,
                       input int in, input bit req, input bit ab, output exp_t e);
    int q[$];
    int line;
    int f;
    q = d ? plan1 : plan0;
    line = -1;
    e.valid = 0;
    e.busy = 0;
    e.done = 0;
    if (r) q.delete();
    else if (q.size() != 0) begin
      if (ab && q[0] >= 0) q.delete();
      else begin
        f = q.pop_front();
        line = (f >= 0) ? f : -1;
        e.busy = (f != -2);
        e.done = (f == -1);
      end
    end else if (req) begin
      e.busy = 1;
      for (int k = 0; k < w; k++) q.push_back(k);
      q.push_back(-1);
      q.push_back(-2);
    end else if (en) begin
      line = in % w;
      e.valid = 1;
    end
    e.out = (line < 0) ? 64'd0 : (64'd1 << line);
    if (al) e.out = ~e.out;
    e.out &= (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (d) plan1 = q;
    else plan0 = q;
  endtask
  task automatic cyc(input bit r, input bit en, input int in, input bit req, input bit ab);
    exp_t e;
    @(negedge clk);
    reset = r;
    b0.enable = en; b0.IN = 3'(in); b0.sweep_req = req; b0.sweep_abort = ab;
    b1.enable = en; b1.IN = 5'(in); b1.sweep_req = req; b1.sweep_abort = ab;
    model(0, 8, 0, r, en, in % 8, req, ab, e);
    sb0.push_back(e);
    model(1, 32, 1, r, en, in % 32, req, ab, e);
    sb1.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() != 0) begin
        e = sb0.pop_front();
        chk("d0_out", 64'(b0.OUT), e.out);
        chk("d0_valid", 64'(b0.valid), 64'(e.valid));
        chk("d0_busy", 64'(b0.busy), 64'(e.busy));
        chk("d0_done", 64'(b0.done), 64'(e.done));
      end
      if (sb1.size() != 0) begin
        e = sb1.pop_front();
        chk("d1_out", 64'(b1.OUT), e.out);
        chk("d1_valid", 64'(b1.valid), 64'(e.valid));
        chk("d1_busy", 64'(b1.busy), 64'(e.busy));
        chk("d1_done", 64'(b1.done), 64'(e.done));
      end
    end
  end
  initial begin
    reset = 1;
    b0.enable = 0; b0.IN = 0; b0.sweep_req = 0; b0.sweep_abort = 0;
    b1.enable = 0; b1.IN = 0; b1.sweep_req = 0; b1.sweep_abort = 0;
    repeat (2) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, i, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (11) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 5, 0, 0);
    cyc(0, 1, 2, 1, 0);
    repeat (12) cyc(0, 1, 3, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 6, 0, 0);
    cyc(0, 1, 31, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (36) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8);
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb0.size() + sb1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
